// File: rtl/kernel_window_buffer.sv
// Sliding n x n kernel window assembled from a column-serial pixel stream.
// Samples arrive top to bottom within a column, columns left to right. Each
// completed column shifts the window one column left. Once n_reg columns have
// been seen, every further column produces a window for the sorter through a
// valid/ready handshake. Out-of-image samples are stored as 0 with a clear mask bit.
module kernel_window_buffer #(
  parameter int PIX      = 8,
  parameter int WORD     = 9,
  parameter int MAX_SIDE = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WORD-1:0]                  n,
  input  logic                             line_start,
  input  logic                             s_valid,
  input  logic                             s_inb,
  input  logic [PIX-1:0]                   s_data,
  output logic [MAX_SIDE*MAX_SIDE*PIX-1:0] win_data,
  output logic [MAX_SIDE*MAX_SIDE-1:0]     win_mask,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic                             overrun,
  output logic                             cfg_err
);

  localparam int CW   = $clog2(MAX_SIDE + 1);
  localparam int COLW = MAX_SIDE * PIX;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t            state_reg;
  logic [WORD-1:0]   n_reg;
  logic [CW-1:0]     row_cnt_reg;
  logic [CW-1:0]     col_cnt_reg;
  logic              win_valid_reg;
  logic              overrun_reg;
  logic              cfg_err_reg;

  // Column under construction; row r lives at [r*PIX +: PIX].
  logic [COLW-1:0]     shd_data_reg;
  logic [MAX_SIDE-1:0] shd_mask_reg;

  // Window storage, one packed column per entry, column 0 is the oldest.
  logic [COLW-1:0]     win_col_reg  [MAX_SIDE];
  logic [MAX_SIDE-1:0] win_cmask_reg[MAX_SIDE];

  logic                n_legal;
  logic                take;
  logic                row_last;
  logic                col_done;
  logic                emit;
  logic [PIX-1:0]      sample_data;
  logic [COLW-1:0]     col_fill_data;
  logic [MAX_SIDE-1:0] col_fill_mask;
  logic [COLW-1:0]     col_next_data[MAX_SIDE];
  logic [MAX_SIDE-1:0] col_next_mask[MAX_SIDE];
  logic [MAX_SIDE-1:0] col_load;

  assign n_legal     = (n != '0) && n[0] && (n <= WORD'(MAX_SIDE));
  // line_start wins over a sample arriving in the same cycle.
  assign take        = (state_reg != IDLE) && s_valid && !line_start;
  assign row_last    = (WORD'(row_cnt_reg) == n_reg - WORD'(1));
  assign col_done    = take && row_last;
  // A window is produced once this completion brings the column count to n_reg.
  assign emit        = col_done && (WORD'(col_cnt_reg) + WORD'(1) >= n_reg);
  assign sample_data = s_inb ? s_data : '0;

  // Shadow column with the current sample merged in at row_cnt.
  always_comb begin
    col_fill_data = shd_data_reg;
    col_fill_mask = shd_mask_reg;
    for (int r = 0; r < MAX_SIDE; r++) begin
      if (row_cnt_reg == CW'(r)) begin
        col_fill_data[r*PIX +: PIX] = sample_data;
        col_fill_mask[r]            = s_inb;
      end
    end
  end

  // Per-column shift source: right neighbour, or the completed column at n_reg-1.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_SIDE; gi++) begin : g_col
      if (gi < MAX_SIDE - 1) begin : g_shift
        assign col_next_data[gi] = (WORD'(gi) == n_reg - WORD'(1)) ? col_fill_data
                                                                   : win_col_reg[gi+1];
        assign col_next_mask[gi] = (WORD'(gi) == n_reg - WORD'(1)) ? col_fill_mask
                                                                   : win_cmask_reg[gi+1];
      end else begin : g_last
        assign col_next_data[gi] = col_fill_data;
        assign col_next_mask[gi] = col_fill_mask;
      end
      assign col_load[gi] = col_done && (WORD'(gi) < n_reg);
      assign win_data[gi*COLW +: COLW]         = win_col_reg[gi];
      assign win_mask[gi*MAX_SIDE +: MAX_SIDE] = win_cmask_reg[gi];
    end
  endgenerate

  // Control: state, geometry capture, counters, handshake and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      n_reg         <= WORD'(1);
      row_cnt_reg   <= '0;
      col_cnt_reg   <= '0;
      win_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else if (line_start) begin
      n_reg         <= n;
      row_cnt_reg   <= '0;
      col_cnt_reg   <= '0;
      win_valid_reg <= 1'b0;
      if (n_legal) begin
        state_reg <= FILL;
      end else begin
        state_reg   <= IDLE;
        cfg_err_reg <= 1'b1;
      end
    end else begin
      if (take) begin
        if (row_last) begin
          row_cnt_reg <= '0;
          if (WORD'(col_cnt_reg) < n_reg) begin
            col_cnt_reg <= col_cnt_reg + CW'(1);
          end
        end else begin
          row_cnt_reg <= row_cnt_reg + CW'(1);
        end
      end
      if (emit) begin
        state_reg     <= STREAM;
        win_valid_reg <= 1'b1;
        // A pending window that was never accepted is being replaced.
        if (win_valid_reg && !win_ready) begin
          overrun_reg <= 1'b1;
        end
      end else if (win_valid_reg && win_ready) begin
        win_valid_reg <= 1'b0;
      end
    end
  end

  // Shadow column capture.
  always_ff @(posedge clk) begin
    if (!rst || line_start) begin
      shd_data_reg <= '0;
      shd_mask_reg <= '0;
    end else if (take) begin
      shd_data_reg <= col_fill_data;
      shd_mask_reg <= col_fill_mask;
    end
  end

  // Window storage: shifts only on a completed column, so it holds while pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < MAX_SIDE; c++) begin
        win_col_reg[c]   <= '0;
        win_cmask_reg[c] <= '0;
      end
    end else if (line_start) begin
      for (int c = 0; c < MAX_SIDE; c++) begin
        win_cmask_reg[c] <= '0;
      end
    end else begin
      for (int c = 0; c < MAX_SIDE; c++) begin
        if (col_load[c]) begin
          win_col_reg[c]   <= col_next_data[c];
          win_cmask_reg[c] <= col_next_mask[c];
        end
      end
    end
  end

  assign win_valid = win_valid_reg;
  assign overrun   = overrun_reg;
  assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_kernel_window_buffer.sv
// Directed bench for kernel_window_buffer: fill, streaming, image edge,
// overrun, illegal kernel size, reset mid-line and the 1x1 kernel.
module tb_kernel_window_buffer;

  localparam int PIX  = 8;
  localparam int WORD = 9;
  localparam int MS   = 5;
  localparam int WW   = MS * MS * PIX;

  logic            clk;
  logic            rst;
  logic [WORD-1:0] n;
  logic            line_start;
  logic            s_valid;
  logic            s_inb;
  logic [PIX-1:0]  s_data;
  logic [WW-1:0]   win_data;
  logic [MS*MS-1:0] win_mask;
  logic            win_valid;
  logic            win_ready;
  logic            overrun;
  logic            cfg_err;

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;

  kernel_window_buffer #(.PIX(PIX), .WORD(WORD), .MAX_SIDE(MS)) dut (
    .clk(clk), .rst(rst), .n(n), .line_start(line_start),
    .s_valid(s_valid), .s_inb(s_inb), .s_data(s_data),
    .win_data(win_data), .win_mask(win_mask), .win_valid(win_valid),
    .win_ready(win_ready), .overrun(overrun), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted windows.
  always @(posedge clk) begin
    if (rst && win_valid && win_ready) xfer_cnt <= xfer_cnt + 1;
  end

  // Expected 3x3 window: column c holds b, b+1, b+2 (b=0 means an all-zero column).
  function automatic logic [WW-1:0] win3(input int b0, input int b1, input int b2);
    logic [WW-1:0] v;
    int b[3];
    v = '0;
    b[0] = b0; b[1] = b1; b[2] = b2;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        if (b[c] != 0) v[((c*MS)+r)*PIX +: PIX] = 8'(b[c] + r);
    return v;
  endfunction

  task automatic drive_sample(input logic [7:0] d, input logic inb);
    s_valid = 1'b1; s_data = d; s_inb = inb;
    @(negedge clk);
    s_valid = 1'b0; s_inb = 1'b0; s_data = '0;
  endtask

  task automatic do_line_start(input int nv);
    line_start = 1'b1; n = WORD'(nv);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", win_valid); end
    checks++; if (win_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", win_data); end
    checks++; if (win_mask !== '0) begin errors++; $display("FAIL reset_mask got=%h exp=0", win_mask); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%0b exp=0", cfg_err); end
    rst = 1'b1;
    @(negedge clk);
    // IDLE ignores samples
    repeat (3) drive_sample(8'h55, 1'b1);
    checks++; if (win_mask !== '0 || win_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore got mask=%h valid=%0b exp mask=0 valid=0", win_mask, win_valid); end
    $display("test_reset done");
  endtask

  task automatic test_fill_3x3;
    do_line_start(3);
    for (int k = 1; k <= 8; k++) begin
      drive_sample(8'(k), 1'b1);
      if (k == 5) repeat (2) @(negedge clk);  // stream pause
    end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL fill_early_valid got=%0b exp=0", win_valid); end
    drive_sample(8'd9, 1'b1);
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got=%0b exp=1", win_valid); end
    checks++; if (win_data !== win3(1, 4, 7)) begin errors++; $display("FAIL fill_data got=%h exp=%h", win_data, win3(1, 4, 7)); end
    checks++; if (win_mask !== 25'h0001CE7) begin errors++; $display("FAIL fill_mask got=%h exp=%h", win_mask, 25'h0001CE7); end
    $display("test_fill_3x3 done");
  endtask

  task automatic test_stream;
    int base;
    base = xfer_cnt;
    win_ready = 1'b1;
    drive_sample(8'd10, 1'b1);
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL stream_accept got=%0b exp=0", win_valid); end
    drive_sample(8'd11, 1'b1);
    drive_sample(8'd12, 1'b1);
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL stream_valid2 got=%0b exp=1", win_valid); end
    checks++; if (win_data !== win3(4, 7, 10)) begin errors++; $display("FAIL stream_data2 got=%h exp=%h", win_data, win3(4, 7, 10)); end
    @(negedge clk);
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%0b exp=0", win_valid); end
    checks++; if (xfer_cnt - base !== 2) begin errors++; $display("FAIL stream_xfers got=%0d exp=2", xfer_cnt - base); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL stream_overrun got=%0b exp=0", overrun); end
    win_ready = 1'b0;
    $display("test_stream done");
  endtask

  task automatic test_left_edge;
    do_line_start(3);
    checks++; if (win_valid !== 1'b0 || win_mask !== '0) begin errors++; $display("FAIL ls_clear got valid=%0b mask=%h exp 0/0", win_valid, win_mask); end
    repeat (3) drive_sample(8'hAA, 1'b0);
    for (int k = 21; k <= 26; k++) drive_sample(8'(k), 1'b1);
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL edge_valid got=%0b exp=1", win_valid); end
    checks++; if (win_data !== win3(0, 21, 24)) begin errors++; $display("FAIL edge_data got=%h exp=%h", win_data, win3(0, 21, 24)); end
    checks++; if (win_mask !== 25'h0001CE0) begin errors++; $display("FAIL edge_mask got=%h exp=%h", win_mask, 25'h0001CE0); end
    $display("test_left_edge done");
  endtask

  task automatic test_overrun;
    drive_sample(8'd31, 1'b1);
    drive_sample(8'd32, 1'b1);
    checks++; if (win_data !== win3(0, 21, 24)) begin errors++; $display("FAIL hold_data got=%h exp=%h", win_data, win3(0, 21, 24)); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hold_overrun got=%0b exp=0", overrun); end
    drive_sample(8'd33, 1'b1);
    checks++; if (overrun !== 1'b1 || win_valid !== 1'b1) begin errors++; $display("FAIL ovr_flag got overrun=%0b valid=%0b exp 1/1", overrun, win_valid); end
    checks++; if (win_data !== win3(21, 24, 31)) begin errors++; $display("FAIL ovr_data got=%h exp=%h", win_data, win3(21, 24, 31)); end
    checks++; if (win_mask !== 25'h0001CE7) begin errors++; $display("FAIL ovr_mask got=%h exp=%h", win_mask, 25'h0001CE7); end
    for (int k = 34; k <= 39; k++) drive_sample(8'(k), 1'b1);
    checks++; if (win_data !== win3(31, 34, 37)) begin errors++; $display("FAIL ovr_data3 got=%h exp=%h", win_data, win3(31, 34, 37)); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
    win_ready = 1'b1;
    @(negedge clk);
    win_ready = 1'b0;
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%0b exp=0", win_valid); end
    $display("test_overrun done");
  endtask

  task automatic test_cfg_err;
    int seen;
    logic [WW-1:0] exp_w;
    seen = 0;
    do_line_start(4);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_even got=%0b exp=1", cfg_err); end
    for (int k = 0; k < 20; k++) begin
      drive_sample(8'(k + 1), 1'b1);
      if (win_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL cfg_no_window got=%0d exp=0", seen); end
    do_line_start(5);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_sticky got=%0b exp=1", cfg_err); end
    for (int k = 0; k < 24; k++) drive_sample(8'(k + 1), 1'b1);
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL n5_early got=%0b exp=0", win_valid); end
    drive_sample(8'd25, 1'b1);
    exp_w = '0;
    for (int c = 0; c < MS; c++)
      for (int r = 0; r < MS; r++)
        exp_w[((c*MS)+r)*PIX +: PIX] = 8'((c*MS) + r + 1);
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL n5_valid got=%0b exp=1", win_valid); end
    checks++; if (win_data !== exp_w) begin errors++; $display("FAIL n5_data got=%h exp=%h", win_data, exp_w); end
    checks++; if (win_mask !== 25'h1FFFFFF) begin errors++; $display("FAIL n5_mask got=%h exp=%h", win_mask, 25'h1FFFFFF); end
    $display("test_cfg_err done");
  endtask

  task automatic test_reset_midline;
    do_line_start(3);
    for (int k = 91; k <= 95; k++) drive_sample(8'(k), 1'b1);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (win_data !== '0 || win_mask !== '0 || win_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out got data=%h mask=%h valid=%0b exp all 0", win_data, win_mask, win_valid); end
    checks++; if (cfg_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got cfg_err=%0b overrun=%0b exp 0/0", cfg_err, overrun); end
    rst = 1'b1;
    @(negedge clk);
    do_line_start(3);
    for (int k = 1; k <= 8; k++) drive_sample(8'(k), 1'b1);
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_early got=%0b exp=0", win_valid); end
    drive_sample(8'd9, 1'b1);
    checks++; if (win_data !== win3(1, 4, 7)) begin errors++; $display("FAIL rst_mid_data got=%h exp=%h", win_data, win3(1, 4, 7)); end
    checks++; if (win_mask !== 25'h0001CE7) begin errors++; $display("FAIL rst_mid_mask got=%h exp=%h", win_mask, 25'h0001CE7); end
    win_ready = 1'b1;
    @(negedge clk);
    win_ready = 1'b0;
    $display("test_reset_midline done");
  endtask

  task automatic test_n1;
    do_line_start(1);
    drive_sample(8'd50, 1'b1);
    checks++; if (win_valid !== 1'b1 || win_data[7:0] !== 8'd50) begin errors++; $display("FAIL n1_first got valid=%0b pix=%0d exp 1/50", win_valid, win_data[7:0]); end
    checks++; if (win_mask !== 25'h0000001) begin errors++; $display("FAIL n1_mask got=%h exp=1", win_mask); end
    win_ready = 1'b1;
    drive_sample(8'd51, 1'b1);  // transfer and new window on the same edge
    checks++; if (win_valid !== 1'b1 || win_data[7:0] !== 8'd51) begin errors++; $display("FAIL n1_b2b got valid=%0b pix=%0d exp 1/51", win_valid, win_data[7:0]); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL n1_no_overrun got=%0b exp=0", overrun); end
    @(negedge clk);
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL n1_drain got=%0b exp=0", win_valid); end
    win_ready = 1'b0;
    do_line_start(7);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_too_big got=%0b exp=1", cfg_err); end
    drive_sample(8'd60, 1'b1);
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL cfg_idle_ignore got=%0b exp=0", win_valid); end
    $display("test_n1 done");
  endtask

  initial begin
    rst = 1'b0; n = '0; line_start = 1'b0; s_valid = 1'b0;
    s_inb = 1'b0; s_data = '0; win_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_3x3();
    test_stream();
    test_left_edge();
    test_overrun();
    test_cfg_err();
    test_reset_midline();
    test_n1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
